// File: rtl/ha_serial_add_seq.sv
// Bit-serial adder for Tiny Tapeout. Two half adders and one carry register form a
// full-adder slice that is used once per clock, LSB first, over WIDTH cycles.

module ha_cell (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;
endmodule

module ha_serial_add_seq #(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [1:0] dbg_state_o
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic             start_q;
   logic [WIDTH-1:0] sa_q, sb_q, res_q, sum_q;
   logic             carry_q, cout_q, busy_q, done_q;
   logic [CW-1:0]    cnt_q;

   logic             h1_s, h1_c, h2_s, h2_c;
   logic             carry_d;
   logic [WIDTH-1:0] res_d;
   logic             trigger;
   logic             unused_ok;

   ha_cell u_ha1 (.a_i(sa_q[0]), .b_i(sb_q[0]), .s_o(h1_s), .c_o(h1_c));
   ha_cell u_ha2 (.a_i(h1_s),    .b_i(carry_q), .s_o(h2_s), .c_o(h2_c));

   assign carry_d = h1_c | h2_c;
   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   assign res_d   = {h2_s, res_q[WIDTH-1:1]};
   assign trigger = uio_in[0] & ~start_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (ena) begin
         start_q <= uio_in[0];
         case (state_q)
            S_IDLE, S_DONE: begin
               if (trigger) begin
                  sa_q    <= uio_in[1] ? sum_q : ui_in[3:0];
                  sb_q    <= ui_in[7:4];
                  carry_q <= 1'b0;
                  cnt_q   <= '0;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_ADD;
               end
            end
            S_ADD: begin
               sa_q    <= sa_q >> 1;
               sb_q    <= sb_q >> 1;
               carry_q <= carry_d;
               res_q   <= res_d;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  sum_q   <= res_d;
                  cout_q  <= carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign uo_out      = {1'b0, done_q, busy_q, cout_q, sum_q};
   assign uio_out     = 8'h00;
   assign uio_oe      = 8'h00;
   assign dbg_state_o = state_q;
   assign unused_ok   = &{1'b0, uio_in[7:2]};

endmodule
